cu_next_state: RTL and testbench
================================

Name: cu_next_state

Overview:
- Sequencing half of the multicycle RISC-V control unit.
- Holds the 5-bit state register that feeds the control-signal decoder directly downstream.
- Computes the next state from the current state, the IR opcode and a memory-ready handshake.
- Also flags illegal opcodes (trap state) and counts retired instructions.

Parameters:
COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  synchronous reset, active low; sampled on the rising edge of clk.
opcode  input  7  IR[6:0]; valid from state 1 onward, stable until the next fetch.
mem_ready  input  1  memory handshake; 1 = the access in the current memory state completes this cycle.
StateRegister  output  5  current state, registered; drives the downstream control decoder.
instr_done  output  1  registered; one-cycle pulse when an instruction completes.
retired_count  output  COUNT_WIDTH  number of completed instructions, registered, wraps.
trap  output  1  registered; 1 while StateRegister = 16.

Behaviour:
- Reset (reset_n = 0 at a clk edge) applies regardless of current state, including mid-instruction:
  - StateRegister = 0, instr_done = 0, retired_count = 0, trap = 0.
  - An aborted instruction is not counted.
- All outputs are registers. Next state is combinational from StateRegister, opcode and mem_ready.
- Opcode decode:
  - LOAD 0000011, STORE 0100011, OP 0110011, BRANCH 1100011
  - JAL 1101111, JALR 1100111, OP-IMM 0010011, LUI 0110111, AUIPC 0010111
- Transitions (current -> next):
  - 0 (fetch) -> 1 if mem_ready, else hold at 0.
  - 1 (decode) -> by opcode:
    - LOAD/STORE -> 2
    - OP -> 6
    - BRANCH -> 8
    - JAL/JALR -> 9
    - AUIPC -> 11
    - OP-IMM -> 13
    - LUI -> 15
    - any other -> 16
  - 2 -> 3 (LOAD), 5 (STORE), otherwise 16.
  - 3 (mem read) -> 4 if mem_ready, else hold.
  - 4 -> 0 (done).
  - 5 (mem write) -> 0 (done) if mem_ready, else hold.
  - 6 -> 7.
  - 7 -> 0 (done).
  - 8 -> 14.
  - 14 -> 0 (done).
  - 9 -> 10 (JAL), 12 (JALR), otherwise 16.
  - 10 -> 0 (done).
  - 12 -> 0 (done).
  - 11, 13, 15 -> 7.
  - 16 (trap) -> 16 until reset.
  - Codes 17..31 -> 16.
- "done" transitions:
  - On the same edge that loads StateRegister = 0, instr_done <= 1 and retired_count <= retired_count + 1.
  - On every other edge, instr_done <= 0.
  - A hold at state 0 (mem_ready = 0) never asserts instr_done.
- retired_count is unsigned modulo 2^COUNT_WIDTH: all-ones + 1 -> 0, with no flag.
- trap <= 1 on the edge entering 16 and remains 1 until reset. retired_count is frozen while in 16.
- mem_ready is ignored in states other than 0, 3 and 5.
- Minimum latencies with mem_ready tied to 1, in cycles from fetch to the next fetch:
  - LOAD 5, STORE 4, OP 4, OP-IMM 4, LUI 4, AUIPC 4, BRANCH 4, JAL 4, JALR 4.

Test Plan:
- Reset: hold reset_n = 0 for 2 edges while StateRegister = 7 -> StateRegister = 0, retired_count = 0, trap = 0, instr_done = 0. Repeat with reset asserted in state 3 -> 0, count unchanged at 0.
- LOAD with stalls: opcode 0000011; mem_ready = 0 for 2 cycles in state 0 and 1 cycle in state 3 -> sequence 0,0,0,1,2,3,3,4,0. instr_done pulses once, on arrival at 0; retired_count = 1.
- Mixed stream, mem_ready = 1:
  - OP -> 0,1,6,7,0
  - BRANCH -> 0,1,8,14,0
  - JALR -> 0,1,9,12,0
  - LUI -> 0,1,15,7,0
  - Result: retired_count = 4 and exactly 4 instr_done pulses.
- Illegal opcode 1111111 at decode -> StateRegister 1 -> 16, trap = 1. Toggling mem_ready and opcode leaves state at 16 and retired_count unchanged; reset_n = 0 -> state 0, trap = 0.
- Counter wrap with COUNT_WIDTH = 4: complete 16 STOREs (mem_ready = 1) -> retired_count goes 15 -> 0 on the 16th instr_done, with no other side effect.
- Force StateRegister code 20 via a bench backdoor -> next edge StateRegister = 16, trap = 1.

Source files
------------

// File: rtl/cu_next_state.sv
// cu_next_state: sequencing half of the multicycle RISC-V control unit.
// Holds the state register that feeds the control-signal decoder, computes
// the next state from the current state, the IR opcode and the memory-ready
// handshake, raises a sticky trap for illegal opcodes and counts retired
// instructions.
module cu_next_state #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [6:0]             opcode,
    input  logic                   mem_ready,
    output logic [4:0]             StateRegister,
    output logic                   instr_done,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output logic                   trap
);

    // State encoding; the numeric codes are consumed directly by the
    // downstream control decoder, so they must not be renumbered.
    typedef enum logic [4:0] {
        S_FETCH       = 5'd0,
        S_DECODE      = 5'd1,
        S_MEM_ADDR    = 5'd2,
        S_MEM_READ    = 5'd3,
        S_MEM_WB      = 5'd4,
        S_MEM_WRITE   = 5'd5,
        S_EXEC_R      = 5'd6,
        S_ALU_WB      = 5'd7,
        S_BRANCH      = 5'd8,
        S_JUMP        = 5'd9,
        S_JAL_WB      = 5'd10,
        S_AUIPC       = 5'd11,
        S_JALR_WB     = 5'd12,
        S_EXEC_I      = 5'd13,
        S_BRANCH_DONE = 5'd14,
        S_LUI         = 5'd15,
        S_TRAP        = 5'd16
    } stateType;

    // RV32I base opcodes (IR[6:0]).
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    // One flag per recognised opcode; all zero means illegal.
    typedef struct packed {
        logic isLoad;
        logic isStore;
        logic isOp;
        logic isBranch;
        logic isJal;
        logic isJalr;
        logic isAuipc;
        logic isOpImm;
        logic isLui;
    } opClassType;

    opClassType opClass;
    stateType   nextState;
    logic       completes;

    // Classify the opcode once so the sequencing logic reads by name.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        opClass = '0;
        case (opcode)
            OPC_LOAD:   opClass.isLoad   = 1'b1;
            OPC_STORE:  opClass.isStore  = 1'b1;
            OPC_OP:     opClass.isOp     = 1'b1;
            OPC_BRANCH: opClass.isBranch = 1'b1;
            OPC_JAL:    opClass.isJal    = 1'b1;
            OPC_JALR:   opClass.isJalr   = 1'b1;
            OPC_AUIPC:  opClass.isAuipc  = 1'b1;
            OPC_OPIMM:  opClass.isOpImm  = 1'b1;
            OPC_LUI:    opClass.isLui    = 1'b1;
            default:    opClass          = '0;
        endcase
    end

    // Next-state selection and instruction-completion detection.
    always_comb begin
        nextState = S_TRAP;
        completes = 1'b0;
        case (StateRegister)
            S_FETCH: begin
                nextState = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if (opClass.isLoad || opClass.isStore) begin
                    nextState = S_MEM_ADDR;
                end else if (opClass.isOp) begin
                    nextState = S_EXEC_R;
                end else if (opClass.isBranch) begin
                    nextState = S_BRANCH;
                end else if (opClass.isJal || opClass.isJalr) begin
                    nextState = S_JUMP;
                end else if (opClass.isAuipc) begin
                    nextState = S_AUIPC;
                end else if (opClass.isOpImm) begin
                    nextState = S_EXEC_I;
                end else if (opClass.isLui) begin
                    nextState = S_LUI;
                end else begin
                    nextState = S_TRAP;
                end
            end
            S_MEM_ADDR: begin
                if (opClass.isLoad) begin
                    nextState = S_MEM_READ;
                end else if (opClass.isStore) begin
                    nextState = S_MEM_WRITE;
                end else begin
                    nextState = S_TRAP;
                end
            end
            S_MEM_READ: begin
                nextState = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                nextState = S_FETCH;
                completes = 1'b1;
            end
            S_MEM_WRITE: begin
                nextState = mem_ready ? S_FETCH : S_MEM_WRITE;
                completes = mem_ready;
            end
            S_EXEC_R: begin
                nextState = S_ALU_WB;
            end
            S_ALU_WB: begin
                nextState = S_FETCH;
                completes = 1'b1;
            end
            S_BRANCH: begin
                nextState = S_BRANCH_DONE;
            end
            S_BRANCH_DONE: begin
                nextState = S_FETCH;
                completes = 1'b1;
            end
            S_JUMP: begin
                if (opClass.isJal) begin
                    nextState = S_JAL_WB;
                end else if (opClass.isJalr) begin
                    nextState = S_JALR_WB;
                end else begin
                    nextState = S_TRAP;
                end
            end
            S_JAL_WB, S_JALR_WB: begin
                nextState = S_FETCH;
                completes = 1'b1;
            end
            S_AUIPC, S_EXEC_I, S_LUI: begin
                nextState = S_ALU_WB;
            end
            S_TRAP: begin
                nextState = S_TRAP;
            end
            // Unused codes 17..31 fall into the trap.
            default: begin
                nextState = S_TRAP;
            end
        endcase
    end

    // State register, completion pulse, retired counter and sticky trap flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!reset_n) begin
            StateRegister <= S_FETCH;
            instr_done    <= 1'b0;
            retired_count <= '0;
            trap          <= 1'b0;
        end else begin
            StateRegister <= nextState;
            instr_done    <= completes;
            if (completes) begin
                retired_count <= retired_count + COUNT_ONE;
            end
            trap <= (nextState == S_TRAP);
        end
    end

endmodule

// File: tb/tb_cu_next_state.sv
// Self-checking bench for cu_next_state: expected state/pulse/count/trap are
// pushed to a scoreboard as each cycle's stimulus is driven and popped when
// the outputs are sampled after the edge.
module tb_cu_next_state;

    localparam int CW = 4;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] ILLEGAL = 7'b1111111;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [6:0]    opcode;
    logic          mem_ready;
    logic [4:0]    StateRegister;
    logic          instr_done;
    logic [CW-1:0] retired_count;
    logic          trap;

    cu_next_state #(.COUNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .StateRegister(StateRegister),
        .instr_done   (instr_done),
        .retired_count(retired_count),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    state;
        logic          done;
        logic [CW-1:0] count;
        logic          trap;
    } expType;

    expType        scoreboard[$];
    int            errors = 0;
    int            checks = 0;
    int            donePulses = 0;
    logic [CW-1:0] expCount = '0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One clock of stimulus plus the outputs expected right after that edge.
    task automatic step(input logic rn, input logic [6:0] op, input logic mr,
                        input logic [4:0] expState, input logic expDone, input string tag);
        expType e;
        @(negedge clk);
        reset_n   = rn;
        opcode    = op;
        mem_ready = mr;
        if (!rn) expCount = '0;
        else if (expDone) expCount = expCount + 1'b1;
        e.state = expState;
        e.done  = expDone;
        e.count = expCount;
        e.trap  = (expState == 5'd16);
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        e = scoreboard.pop_front();
        if (instr_done === 1'b1) donePulses++;
        check({tag, ".state"}, StateRegister, e.state);
        check({tag, ".done"},  instr_done,    e.done);
        check({tag, ".count"}, retired_count, e.count);
        check({tag, ".trap"},  trap,          e.trap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n   = 1'b0;
        opcode    = 7'd0;
        mem_ready = 1'b0;

        // Power-on reset for two edges.
        step(0, 7'd0, 0, 0, 0, "por0");
        step(0, 7'd0, 0, 0, 0, "por1");

        // Reset mid-instruction in state 7: the aborted OP is not counted.
        step(1, OP, 1, 1, 0, "r7.a");
        step(1, OP, 1, 6, 0, "r7.b");
        step(1, OP, 1, 7, 0, "r7.c");
        step(0, OP, 1, 0, 0, "r7.rst0");
        step(0, OP, 1, 0, 0, "r7.rst1");

        // Reset mid-instruction in state 3.
        step(1, LOAD, 1, 1, 0, "r3.a");
        step(1, LOAD, 1, 2, 0, "r3.b");
        step(1, LOAD, 1, 3, 0, "r3.c");
        step(0, LOAD, 1, 0, 0, "r3.rst0");
        step(0, LOAD, 1, 0, 0, "r3.rst1");

        // LOAD with stalls in fetch and in the memory read.
        step(1, LOAD, 0, 0, 0, "ld.hold0");
        step(1, LOAD, 0, 0, 0, "ld.hold1");
        step(1, LOAD, 1, 1, 0, "ld.s1");
        step(1, LOAD, 1, 2, 0, "ld.s2");
        step(1, LOAD, 1, 3, 0, "ld.s3");
        step(1, LOAD, 0, 3, 0, "ld.stall3");
        step(1, LOAD, 1, 4, 0, "ld.s4");
        step(1, LOAD, 1, 0, 1, "ld.done");

        // Mixed stream with mem_ready held high.
        donePulses = 0;
        step(1, OP, 1, 1, 0, "op.s1");
        step(1, OP, 1, 6, 0, "op.s6");
        step(1, OP, 1, 7, 0, "op.s7");
        step(1, OP, 1, 0, 1, "op.done");
        step(1, BRANCH, 1, 1, 0, "br.s1");
        step(1, BRANCH, 1, 8, 0, "br.s8");
        step(1, BRANCH, 1, 14, 0, "br.s14");
        step(1, BRANCH, 1, 0, 1, "br.done");
        step(1, JALR, 1, 1, 0, "jalr.s1");
        step(1, JALR, 1, 9, 0, "jalr.s9");
        step(1, JALR, 1, 12, 0, "jalr.s12");
        step(1, JALR, 1, 0, 1, "jalr.done");
        step(1, LUI, 1, 1, 0, "lui.s1");
        step(1, LUI, 1, 15, 0, "lui.s15");
        step(1, LUI, 1, 7, 0, "lui.s7");
        step(1, LUI, 1, 0, 1, "lui.done");
        check("mixed.pulses", donePulses, 4);
        check("mixed.count", retired_count, 5);

        // mem_ready low outside the memory states must not stall.
        step(1, JAL, 1, 1, 0, "jal.s1");
        step(1, JAL, 0, 9, 0, "jal.s9");
        step(1, JAL, 0, 10, 0, "jal.s10");
        step(1, JAL, 0, 0, 1, "jal.done");
        step(1, AUIPC, 1, 1, 0, "auipc.s1");
        step(1, AUIPC, 0, 11, 0, "auipc.s11");
        step(1, AUIPC, 0, 7, 0, "auipc.s7");
        step(1, AUIPC, 1, 0, 1, "auipc.done");
        step(1, OPIMM, 1, 1, 0, "opimm.s1");
        step(1, OPIMM, 1, 13, 0, "opimm.s13");
        step(1, OPIMM, 1, 7, 0, "opimm.s7");
        step(1, OPIMM, 1, 0, 1, "opimm.done");

        // STORE with one stall in the memory write.
        step(1, STORE, 1, 1, 0, "st.s1");
        step(1, STORE, 0, 2, 0, "st.s2");
        step(1, STORE, 0, 5, 0, "st.s5");
        step(1, STORE, 0, 5, 0, "st.stall5");
        step(1, STORE, 1, 0, 1, "st.done");

        // Illegal opcode: sticky trap, counter frozen, only reset leaves.
        step(1, ILLEGAL, 1, 1, 0, "ill.s1");
        step(1, ILLEGAL, 0, 16, 0, "ill.enter");
        step(1, 7'd0, 1, 16, 0, "ill.hold0");
        step(1, LOAD, 0, 16, 0, "ill.hold1");
        step(1, STORE, 1, 16, 0, "ill.hold2");
        step(1, 7'h5a, 0, 16, 0, "ill.hold3");
        step(0, ILLEGAL, 0, 0, 0, "ill.rst");

        // Opcode no longer LOAD/STORE at state 2 also traps.
        step(1, LOAD, 1, 1, 0, "s2bad.s1");
        step(1, LOAD, 1, 2, 0, "s2bad.s2");
        step(1, OP, 1, 16, 0, "s2bad.trap");
        step(0, OP, 1, 0, 0, "s2bad.rst");

        // Counter wrap: 16 STOREs take the 4-bit count 15 -> 0.
        for (int i = 0; i < 16; i++) begin
            step(1, STORE, 1, 1, 0, "wrap.s1");
            step(1, STORE, 1, 2, 0, "wrap.s2");
            step(1, STORE, 1, 5, 0, "wrap.s5");
            step(1, STORE, 1, 0, 1, "wrap.done");
        end
        check("wrap.count", retired_count, 0);
        check("wrap.trap", trap, 0);

        // Backdoor an unused state code: the next edge must land in the trap.
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        opcode    = LOAD;
        force dut.StateRegister = 5'd20;
        @(posedge clk);
        #1;
        check("bd.trap", trap, 1);
        check("bd.done", instr_done, 0);
        release dut.StateRegister;
        @(posedge clk);
        #1;
        check("bd.state", StateRegister, 16);
        check("bd.trap2", trap, 1);
        check("bd.count", retired_count, 0);

        step(0, 7'd0, 0, 0, 0, "end.rst");
        check("sb.empty", scoreboard.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
